// File: rtl/adder_sevenseg_pkg.sv
// Shared constants for the adder/subtractor seven-segment block:
// blank pattern, active-low hex glyph table and counter width helper.
package adder_sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order g..a, active-low, glyphs 0-9 A b C d E F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to count 0..n-1, never less than one
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = 32'(i + 1);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_seg7
    import adder_sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/adder_sevenseg_n.sv
// N-bit adder/subtractor with registered result and overflow flags, driving a
// time-multiplexed hex seven-segment display that blinks on overflow.
module adder_sevenseg_n
    import adder_sevenseg_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic              clock_100MHz,
    input  logic              reset,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              sub,
    input  logic              load,
    output logic [WIDTH-1:0]  Sum,
    output logic              OV_S,
    output logic              OV_U,
    output logic [6:0]        Seg,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned SUM_W   = WIDTH + 1;
    localparam int unsigned MSB     = WIDTH - 1;
    localparam int unsigned NIBBLES = (WIDTH + 3) / 4;
    localparam int unsigned PAD_W   = NIBBLES * 4;
    localparam int unsigned REF_W   = clog2_min1(REFRESH_DIV);
    localparam int unsigned IDX_W   = clog2_min1(DIGITS);
    localparam int unsigned BLK_W   = clog2_min1(BLINK_DIV);

    logic [WIDTH-1:0]  b_eff_c;
    logic [SUM_W-1:0]  sum_full_c;
    logic [WIDTH-1:0]  r_c;
    logic              carry_c;
    logic              ovu_c;
    logic              ovs_c;

    logic [REF_W-1:0]  refresh_cnt;
    logic              tick_c;
    logic [IDX_W-1:0]  digit_idx;
    logic [BLK_W-1:0]  blink_cnt;
    logic              blink_phase;

    logic [PAD_W-1:0]  sum_pad_c;
    logic [3:0]        nibble_c;
    logic              digit_valid_c;
    logic [6:0]        seg_dec_c;
    logic [6:0]        seg_next_c;
    logic [DIGITS-1:0] an_next_c;

    // Subtraction is A + ~B + 1; a carry-out there means "no borrow"
    always_comb begin
        b_eff_c    = sub ? ~B : B;
        sum_full_c = SUM_W'(A) + SUM_W'(b_eff_c) + SUM_W'(sub);
        r_c        = sum_full_c[WIDTH-1:0];
        carry_c    = sum_full_c[WIDTH];
        ovu_c      = sub ? ~carry_c : carry_c;
        ovs_c      = (A[MSB] == b_eff_c[MSB]) && (r_c[MSB] != A[MSB]);
    end

    always_ff @(posedge clock_100MHz or posedge reset) begin
        if (reset) begin
            Sum  <= '0;
            OV_S <= 1'b0;
            OV_U <= 1'b0;
        end else if (load) begin
            Sum  <= r_c;
            OV_S <= ovs_c;
            OV_U <= ovu_c;
        end
    end

    // Digit-slot timebase
    assign tick_c = (refresh_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge clock_100MHz or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (tick_c) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Digit index and blink phase both advance only on slot ticks
    always_ff @(posedge clock_100MHz or posedge reset) begin
        if (reset) begin
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick_c) begin
            if (digit_idx == IDX_W'(DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + IDX_W'(1);
            end
            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Select the nibble for the current digit; digits past the result are blank
    always_comb begin
        sum_pad_c     = PAD_W'(Sum);
        nibble_c      = 4'(sum_pad_c >> {digit_idx, 2'b00});
        digit_valid_c = (32'(digit_idx) < NIBBLES);
        an_next_c     = ~(DIGITS'(1) << digit_idx);
        seg_next_c    = seg_dec_c;
        if (!digit_valid_c || (blink_phase && (OV_S || OV_U))) begin
            seg_next_c = SEG_BLANK;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_c),
        .seg_c  (seg_dec_c)
    );

    // Scan outputs change only on a tick, so a new Sum never glitches mid-slot
    always_ff @(posedge clock_100MHz or posedge reset) begin
        if (reset) begin
            an  <= '1;
            Seg <= SEG_BLANK;
        end else if (tick_c) begin
            an  <= an_next_c;
            Seg <= seg_next_c;
        end
    end

endmodule

// File: doc/adder_sevenseg_n.md
Name: adder_sevenseg_n

Overview:
Parametrised N-bit adder/subtractor with registered result, signed and unsigned overflow flags, and a time-multiplexed hex seven-segment driver for DIGITS digits. It replaces the fixed 4-bit combinational adder-plus-display lab block on the 100 MHz board clock. Operands are captured on a load strobe. The display scans continuously and blinks while an overflow flag is set.

Parameters:
WIDTH, 8, operand and result width in bits (2..16)
DIGITS, 4, number of seven-segment digits driven (1..8)
REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz)
BLINK_DIV, 250, digit-slot ticks per blink half-period

Ports:
clock_100MHz  in   1          system clock, all logic on rising edge
reset         in   1          asynchronous, active-high; clears all state
A             in   WIDTH      operand A
B             in   WIDTH      operand B
sub           in   1          0 = A+B, 1 = A-B; sampled with load
load          in   1          capture operands and compute on this edge
Sum           out  WIDTH      registered result
OV_S          out  1          signed (two's-complement) overflow of last op
OV_U          out  1          unsigned carry-out (add) or borrow (sub)
Seg           out  7          segments g..a, active-low
an            out  DIGITS     digit enables, active-low, one-hot-low

Behaviour:
- Clock and reset: one clock, clock_100MHz. reset is asynchronous and active-high. On assertion: Sum=0, OV_S=0, OV_U=0, Seg=7'h7F, an=all ones, refresh counter=0, digit index=0, blink counter=0, blink phase=0.
- Arithmetic:
  - On a rising edge with load=1: add gives {c,r} = A+B (WIDTH+1 bits); sub gives r = A + ~B + 1.
  - Sum<=r, registered, so 1-cycle latency.
  - OV_U: carry-out for add; 1 when A<B unsigned for sub.
  - OV_S, add: A[MSB]==B[MSB] and r[MSB]!=A[MSB].
  - OV_S, sub: A[MSB]!=B[MSB] and r[MSB]!=A[MSB].
  - load held high recomputes every cycle. load=0 holds Sum and flags; operand changes without load have no effect.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1. A tick pulses when it wraps.
  - On each tick the digit index advances 0..DIGITS-1 and wraps to 0.
- Scan outputs:
  - an and Seg are registered, updated on the tick.
  - an[idx]=0, all other bits 1. Digit 0 is the rightmost digit, showing Sum[3:0].
  - Digit k shows nibble k of Sum, zero-extended.
  - Digits with k >= ceil(WIDTH/4) show blank (7'h7F) but their enable still scans.
- Blink:
  - The blink counter counts ticks 0..BLINK_DIV-1. Blink phase toggles on wrap.
  - While (OV_S|OV_U)=1 and phase=1, Seg=7'h7F. an is unaffected.
  - With no overflow, phase still runs but is ignored.
- Display timing: the display reflects a new Sum from the first tick after the update. No mid-slot glitch.
- Reset mid-scan: outputs are blanked immediately (asynchronous). Scanning restarts at digit 0 with a full REFRESH_DIV wait before the first tick.
- load and reset together: reset wins.
- WIDTH not a multiple of 4: the top nibble is zero-padded.

Decomposition:
- Package adder_sevenseg_pkg: SEG_BLANK=7'h7F, the 16-entry hex segment constant table (active-low), and a clog2-style function for counter widths.
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.

Test Plan:
- WIDTH=4, A=4'h8, B=4'h8, sub=0, load pulse -> next cycle Sum=0, OV_U=1, OV_S=1. Seg alternates 7'h40 ("0") and 7'h7F at blink rate.
- WIDTH=8, A=8'h7F, B=8'h01, add -> Sum=8'h80, OV_S=1, OV_U=0. Then A=8'h05, B=8'h07, sub -> Sum=8'hFE, OV_U=1, OV_S=0.
- REFRESH_DIV=4, DIGITS=4, Sum=8'h3A -> an cycles E,D,B,7 every 4 clocks. Seg shows "A" (7'h08), "3" (7'h30), blank, blank.
- Change A/B with load=0 -> Sum and flags unchanged. load held 3 cycles with varying operands -> Sum tracks each one cycle late.
- Assert reset asynchronously mid-slot on digit 2 -> Seg=7'h7F, an=4'hF, Sum=0 immediately. After release, first tick after exactly REFRESH_DIV clocks enables digit 0.
- BLINK_DIV=2 with an overflow present, then a load clearing the flags -> blanking stops within one slot of the load.
